// File: rtl/irs3_dac_update_sched_if.sv
// Request, loader and status signals of the IRS3 SBbias DAC update scheduler.
// master drives requests and loader busy; slave is the scheduler itself.
interface irs3_dac_update_sched_if;
    logic        irs_mode_i;
    logic        sw_wr_i;
    logic [11:0] sw_sbbias_i;
    logic        sw_ack_o;
    logic        servo_wr_i;
    logic [11:0] servo_sbbias_i;
    logic        servo_ack_o;
    logic        refresh_en_i;
    logic        err_clr_i;
    logic [11:0] sbbias_o;
    logic        irs_init_o;
    logic        irs_dac_busy_i;
    logic        busy_o;
    logic        pending_o;
    logic [15:0] update_count_o;
    logic        timeout_o;

    modport master (
        output irs_mode_i, sw_wr_i, sw_sbbias_i, servo_wr_i, servo_sbbias_i,
               refresh_en_i, err_clr_i, irs_dac_busy_i,
        input  sw_ack_o, servo_ack_o, sbbias_o, irs_init_o, busy_o, pending_o,
               update_count_o, timeout_o
    );

    modport slave (
        input  irs_mode_i, sw_wr_i, sw_sbbias_i, servo_wr_i, servo_sbbias_i,
               refresh_en_i, err_clr_i, irs_dac_busy_i,
        output sw_ack_o, servo_ack_o, sbbias_o, irs_init_o, busy_o, pending_o,
               update_count_o, timeout_o
    );
endinterface

// File: rtl/irs3_dac_update_sched.sv
// Owns the IRS3 SBbias DAC value: arbitrates sw/servo/refresh requests and
// sequences the serial DAC loader with start/done timeouts and a holdoff gap.
module irs3_dac_update_sched #(
    parameter logic [11:0] SBBIAS_DEFAULT = 12'h7FF,
    parameter int unsigned REFRESH_BITS   = 24,
    parameter int unsigned START_TIMEOUT  = 64,
    parameter int unsigned DONE_TIMEOUT   = 8192,
    parameter int unsigned HOLDOFF        = 16
) (
    input logic                     clk_i,
    input logic                     rst_i,
    irs3_dac_update_sched_if.slave  bus
);

    localparam int unsigned CW = $clog2(START_TIMEOUT + DONE_TIMEOUT + HOLDOFF) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_WAIT_DONE, S_HOLDOFF
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [REFRESH_BITS-1:0] ref_cnt_q, ref_cnt_d;
    logic [11:0]             sbbias_q, sbbias_d;
    logic [11:0]             sw_val_q, sw_val_d, servo_val_q, servo_val_d;
    logic                    sw_pend_q, sw_pend_d, servo_pend_q, servo_pend_d;
    logic                    ref_pend_q, ref_pend_d;
    logic                    sw_ack_q, sw_ack_d, servo_ack_q, servo_ack_d;
    logic                    init_q, init_d, busy_q, busy_d, pending_q, pending_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             count_q, count_d;
    logic                    sw_take, servo_take, ref_take, tmo_set, done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sbbias_d   = sbbias_q;
        sw_take    = 1'b0;
        servo_take = 1'b0;
        ref_take   = 1'b0;
        tmo_set    = 1'b0;
        done       = 1'b0;

        // Selected value is latched on the IDLE->LOAD edge so sbbias_o is
        // already settled for the whole LOAD cycle before init rises.
        case (state_q)
            S_IDLE: begin
                if (bus.irs_mode_i && !bus.irs_dac_busy_i &&
                    (sw_pend_q || servo_pend_q || ref_pend_q)) begin
                    state_d = S_LOAD;
                    if (sw_pend_q) begin
                        sw_take  = 1'b1;
                        sbbias_d = sw_val_q;
                    end else if (servo_pend_q) begin
                        servo_take = 1'b1;
                        sbbias_d   = servo_val_q;
                    end else begin
                        ref_take = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_LAUNCH;
                cnt_d   = '0;
            end
            S_LAUNCH: begin
                if (bus.irs_dac_busy_i) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.irs_dac_busy_i) begin
                    done    = 1'b1;
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = S_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == CW'(HOLDOFF - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A write in the consuming cycle re-arms the flag with the new value.
        sw_pend_d    = (sw_pend_q & ~sw_take) | bus.sw_wr_i;
        sw_val_d     = bus.sw_wr_i ? bus.sw_sbbias_i : sw_val_q;
        servo_pend_d = (servo_pend_q & ~servo_take) | bus.servo_wr_i;
        servo_val_d  = bus.servo_wr_i ? bus.servo_sbbias_i : servo_val_q;
        ref_pend_d   = (ref_pend_q & ~ref_take) | (bus.refresh_en_i && (ref_cnt_q == '1));

        if (state_q == S_LOAD)
            ref_cnt_d = '0;
        else if (bus.refresh_en_i)
            ref_cnt_d = ref_cnt_q + 1'b1;
        else
            ref_cnt_d = ref_cnt_q;

        timeout_d   = tmo_set | (timeout_q & ~bus.err_clr_i);
        count_d     = count_q + {15'd0, done};
        sw_ack_d    = bus.sw_wr_i;
        servo_ack_d = bus.servo_wr_i;
        init_d      = (state_d == S_LAUNCH);
        busy_d      = (state_d != S_IDLE);
        pending_d   = sw_pend_d | servo_pend_d | ref_pend_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ref_cnt_q    <= '0;
            sbbias_q     <= SBBIAS_DEFAULT;
            sw_val_q     <= '0;
            servo_val_q  <= '0;
            sw_pend_q    <= 1'b0;
            servo_pend_q <= 1'b0;
            ref_pend_q   <= 1'b1;
            sw_ack_q     <= 1'b0;
            servo_ack_q  <= 1'b0;
            init_q       <= 1'b0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b1;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            sbbias_q     <= sbbias_d;
            sw_val_q     <= sw_val_d;
            servo_val_q  <= servo_val_d;
            sw_pend_q    <= sw_pend_d;
            servo_pend_q <= servo_pend_d;
            ref_pend_q   <= ref_pend_d;
            sw_ack_q     <= sw_ack_d;
            servo_ack_q  <= servo_ack_d;
            init_q       <= init_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    assign bus.sw_ack_o       = sw_ack_q;
    assign bus.servo_ack_o    = servo_ack_q;
    assign bus.sbbias_o       = sbbias_q;
    assign bus.irs_init_o     = init_q;
    assign bus.busy_o         = busy_q;
    assign bus.pending_o      = pending_q;
    assign bus.update_count_o = count_q;
    assign bus.timeout_o      = timeout_q;

endmodule
